// File: rtl/led_activity_ctrl.sv
// Ethernet TX/RX activity LED controller: stretches activity bursts into visible
// ON periods with a forced dark gap, plus saturating per-channel edge counters.

module led_activity_chan #(
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             act,
    input  logic             pol,
    input  logic             clr_cnt,
    output logic             led,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned TC_W      = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TC_W-1:0] tcnt;
    logic [TC_W-1:0] tcnt_nxt;
    logic            pend;
    logic            pend_nxt;
    logic            act_d;
    logic            act_rise;

    // Next-state logic: ON/OFF periods are measured in shared prescaler ticks
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        pend_nxt  = pend;
        case (state)
            ST_IDLE: begin
                if (act) begin
                    state_nxt = ST_ON;
                    tcnt_nxt  = TC_W'(ON_TICKS);
                end
            end
            ST_ON: begin
                if (act) begin
                    pend_nxt = 1'b1;
                end
                if (tick) begin
                    if (tcnt == TC_W'(1)) begin
                        state_nxt = ST_OFF;
                        tcnt_nxt  = TC_W'(OFF_TICKS);
                    end else begin
                        tcnt_nxt = tcnt - TC_W'(1);
                    end
                end
            end
            ST_OFF: begin
                if (act) begin
                    pend_nxt = 1'b1;
                end
                if (tick) begin
                    if (tcnt == TC_W'(1)) begin
                        if (pend || act) begin
                            // Activity seen since this episode began earns exactly one more ON
                            state_nxt = ST_ON;
                            tcnt_nxt  = TC_W'(ON_TICKS);
                            pend_nxt  = 1'b0;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        tcnt_nxt = tcnt - TC_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tcnt_nxt  = '0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            tcnt  <= '0;
            pend  <= 1'b0;
            led   <= 1'b0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
            pend  <= pend_nxt;
            led   <= (state_nxt == ST_ON) ^ pol;
        end
    end

    assign act_rise = act & ~act_d;

    // Saturating rising-edge counter; clear has priority over a coincident edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_d <= 1'b0;
            cnt   <= '0;
        end else begin
            act_d <= act;
            if (clr_cnt) begin
                cnt <= '0;
            end else if (act_rise && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

module led_activity_ctrl #(
    parameter int unsigned TICK_DIV  = 512,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             act_tx,
    input  logic             act_rx,
    input  logic [1:0]       led_pol,
    input  logic             clr_cnt,
    output logic             led_tx,
    output logic             led_rx,
    output logic [CNT_W-1:0] cnt_tx,
    output logic [CNT_W-1:0] cnt_rx
);

    localparam int unsigned PS_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

    logic [PS_W-1:0] ps_cnt;
    logic            tick;

    assign tick = (ps_cnt == PS_W'(TICK_DIV - 1));

    // Shared LED time-base prescaler
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    led_activity_chan #(
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS),
        .CNT_W     (CNT_W)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .act     (act_tx),
        .pol     (led_pol[1]),
        .clr_cnt (clr_cnt),
        .led     (led_tx),
        .cnt     (cnt_tx)
    );

    led_activity_chan #(
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS),
        .CNT_W     (CNT_W)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .act     (act_rx),
        .pol     (led_pol[0]),
        .clr_cnt (clr_cnt),
        .led     (led_rx),
        .cnt     (cnt_rx)
    );

endmodule

// File: tb/tb_led_activity_ctrl.sv
// Directed bench for led_activity_ctrl with a deadline-based episode model checked every cycle.

module tb_led_activity_ctrl;

    localparam int TD    = 4;
    localparam int ONT   = 2;
    localparam int OFFT  = 1;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          act_tx;
    logic          act_rx;
    logic [1:0]    led_pol;
    logic          clr_cnt;
    logic          led_tx;
    logic          led_rx;
    logic [CW-1:0] cnt_tx;
    logic [CW-1:0] cnt_rx;

    int n_vec;
    int n_err;

    led_activity_ctrl #(
        .TICK_DIV  (TD),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFFT),
        .CNT_W     (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .act_tx  (act_tx),
        .act_rx  (act_rx),
        .led_pol (led_pol),
        .clr_cnt (clr_cnt),
        .led_tx  (led_tx),
        .led_rx  (led_rx),
        .cnt_tx  (cnt_tx),
        .cnt_rx  (cnt_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: an episode started at edge c0 stays lit until the ONT-th tick after c0,
    // then dark for OFFT more ticks; activity seen inside the episode buys one rerun.
    int cyc;
    bit model_ok;
    bit busy    [2];
    bit pend    [2];
    int st      [2];
    int on_end  [2];
    int off_end [2];
    int exp_led [2];
    int exp_cnt [2];
    bit prev    [2];

    task automatic start_ep(input int ch, input int c0);
        int t;
        t = (c0 / TD) * TD + TD - 1;
        if (t <= c0) t += TD;
        busy[ch]    = 1'b1;
        pend[ch]    = 1'b0;
        st[ch]      = c0;
        on_end[ch]  = t + (ONT - 1) * TD;
        off_end[ch] = on_end[ch] + OFFT * TD;
    endtask

    always @(posedge clk) begin
        bit a [2];
        bit p [2];
        a[0] = act_tx;      a[1] = act_rx;
        p[0] = led_pol[1];  p[1] = led_pol[0];
        if (!rst_n) begin
            cyc      = 0;
            model_ok = 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                busy[ch] = 1'b0; pend[ch] = 1'b0; prev[ch] = 1'b0;
                exp_led[ch] = 0; exp_cnt[ch] = 0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (!busy[ch]) begin
                    if (a[ch]) start_ep(ch, cyc);
                end else begin
                    if (a[ch]) pend[ch] = 1'b1;
                    if (cyc == off_end[ch]) begin
                        if (pend[ch]) start_ep(ch, cyc);
                        else busy[ch] = 1'b0;
                    end
                end
                exp_led[ch] = int'((busy[ch] && cyc >= st[ch] && cyc < on_end[ch]) ^ p[ch]);
                if (clr_cnt) exp_cnt[ch] = 0;
                else if (a[ch] && !prev[ch] && exp_cnt[ch] < CMAX) exp_cnt[ch]++;
                prev[ch] = a[ch];
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("led_tx", int'(led_tx), exp_led[0]);
            chk("led_rx", int'(led_rx), exp_led[1]);
            chk("cnt_tx", int'(cnt_tx), exp_cnt[0]);
            chk("cnt_rx", int'(cnt_rx), exp_cnt[1]);
        end
    end

    initial begin
        int dark;
        int lit;
        n_vec = 0; n_err = 0; model_ok = 1'b0;
        rst_n = 1'b0; act_tx = 1'b0; act_rx = 1'b0; led_pol = 2'b00; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led_tx", int'(led_tx), 0);
        chk("rst_cnt_tx", int'(cnt_tx), 0);

        // 1: single pulse sampled at edge 0; first tick edge 3, ON ends edge 7, IDLE at 11
        rst_n = 1'b1; act_tx = 1'b1;
        @(negedge clk); act_tx = 1'b0;
        chk("t1_lit_edge0", int'(led_tx), 1);
        chk("t1_cnt", int'(cnt_tx), 1);
        repeat (6) @(negedge clk);
        chk("t1_lit_edge6", int'(led_tx), 1);
        @(negedge clk);
        chk("t1_dark_edge7", int'(led_tx), 0);
        repeat (10) @(negedge clk);
        chk("t1_idle", int'(led_tx), 0);
        chk("t1_rx_quiet", int'(led_rx), 0);

        // 2: long RX level must blink, not stay lit
        act_rx = 1'b1;
        dark = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (led_rx == 1'b0) dark++;
        end
        act_rx = 1'b0;
        chk("t2_has_dark_gap", int'(dark > 0), 1);
        repeat (20) @(negedge clk);
        chk("t2_cnt_rx", int'(cnt_rx), 1);
        chk("t2_idle", int'(led_rx), 0);

        // 3: pulse during ON -> relight at edge 11 (OFF end), lit until edge 19
        rst_n = 1'b0; @(negedge clk);
        rst_n = 1'b1; act_tx = 1'b1;
        @(negedge clk); act_tx = 1'b0;
        @(negedge clk); act_tx = 1'b1;
        @(negedge clk); act_tx = 1'b0;
        repeat (8) @(negedge clk);
        chk("t3_gap_edge10", int'(led_tx), 0);
        @(negedge clk);
        chk("t3_relit_edge11", int'(led_tx), 1);
        repeat (7) @(negedge clk);
        chk("t3_lit_edge18", int'(led_tx), 1);
        @(negedge clk);
        chk("t3_dark_edge19", int'(led_tx), 0);
        repeat (14) @(negedge clk);
        chk("t3_no_extra_on", int'(led_tx), 0);
        act_tx = 1'b1; @(negedge clk); act_tx = 1'b0;
        repeat (20) @(negedge clk);
        chk("t3_cnt_tx", int'(cnt_tx), 3);

        // 4: active-low polarity, then flip mid-ON
        led_pol = 2'b11;
        @(negedge clk);
        chk("t4_idle_tx_hi", int'(led_tx), 1);
        chk("t4_idle_rx_hi", int'(led_rx), 1);
        act_tx = 1'b1; act_rx = 1'b1;
        @(negedge clk); act_tx = 1'b0; act_rx = 1'b0;
        chk("t4_act_tx_lo", int'(led_tx), 0);
        chk("t4_act_rx_lo", int'(led_rx), 0);
        led_pol = 2'b00;
        @(negedge clk);
        chk("t4_flip_tx", int'(led_tx), 1);
        chk("t4_flip_rx", int'(led_rx), 1);
        repeat (20) @(negedge clk);

        // 5: counter saturation and clear-over-edge priority
        for (int i = 0; i < 20; i++) begin
            act_tx = 1'b1; @(negedge clk);
            act_tx = 1'b0; @(negedge clk);
        end
        chk("t5_sat", int'(cnt_tx), 15);
        act_tx = 1'b1; clr_cnt = 1'b1;
        @(negedge clk); act_tx = 1'b0; clr_cnt = 1'b0;
        chk("t5_clr_tx", int'(cnt_tx), 0);
        chk("t5_clr_rx", int'(cnt_rx), 0);
        repeat (20) @(negedge clk);

        // 6: reset while ON with pending set
        rst_n = 1'b0; @(negedge clk);
        rst_n = 1'b1; act_tx = 1'b1; act_rx = 1'b1;
        @(negedge clk); act_tx = 1'b0; act_rx = 1'b0;
        @(negedge clk); act_tx = 1'b1; act_rx = 1'b1;
        @(negedge clk); act_tx = 1'b0; act_rx = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_led_tx", int'(led_tx), 0);
        chk("t6_rst_led_rx", int'(led_rx), 0);
        chk("t6_rst_cnt_tx", int'(cnt_tx), 0);
        rst_n = 1'b1;
        lit = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (led_tx || led_rx) lit++;
        end
        chk("t6_no_relight", lit, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
